// File: rtl/receptor_limites_serial.sv
// rtl/receptor_limites_serial.sv - 7E1 UART receiver and command parser driving the BCD range limits
module receptor_limites_serial #(
  parameter int          M_BIT     = 434,
  parameter int          N_BIT     = 9,
  parameter logic [11:0] UPPER_DEF = 12'h030,
  parameter logic [11:0] LOWER_DEF = 12'h010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] upperL,
  output logic [11:0] lowerL,
  output logic        limites_atualizados,
  output logic        erro,
  output logic        pronto_rx,
  output logic [6:0]  db_dado,
  output logic [3:0]  db_estado
);

  localparam logic [N_BIT-1:0] HALF = N_BIT'(M_BIT / 2 - 1);
  localparam logic [N_BIT-1:0] FULL = N_BIT'(M_BIT - 1);

  localparam logic [6:0] CH_L    = 7'h4C;
  localparam logic [6:0] CH_U    = 7'h55;
  localparam logic [6:0] CH_HASH = 7'h23;

  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} rx_t;
  typedef enum logic [3:0] {
    ESPERA_CMD  = 4'd0,
    DIG_C       = 4'd1,
    DIG_D       = 4'd2,
    DIG_U       = 4'd3,
    ESPERA_HASH = 4'd4
  } ps_t;

  // ---------------- receiver ----------------
  logic             s1, s2, s3;
  logic             falling, tick;
  rx_t              rx_st, rx_nx;
  logic [N_BIT-1:0] cnt;
  logic [2:0]       idx;
  logic [6:0]       shreg;
  logic             par;
  logic             rx_err;

  // s3 tracks s2 continuously, so a line held low never yields a new edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= entrada_serial;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign falling = s3 & ~s2;
  assign tick    = (rx_st == INICIO) ? (cnt == HALF) : (cnt == FULL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rx_st <= OCIOSO;
    else        rx_st <= rx_nx;
  end

  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      OCIOSO:   if (falling) rx_nx = INICIO;
      INICIO:   if (tick) rx_nx = s2 ? OCIOSO : DADOS;
      DADOS:    if (tick && idx == 3'd6) rx_nx = PARIDADE;
      PARIDADE: if (tick) rx_nx = PARADA;
      PARADA:   if (tick) rx_nx = OCIOSO;
      default:  rx_nx = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      pronto_rx <= 1'b0;
      rx_err    <= 1'b0;
      db_dado   <= '0;
    end else begin
      pronto_rx <= 1'b0;
      rx_err    <= 1'b0;
      cnt       <= (rx_st == OCIOSO || tick) ? '0 : cnt + 1'b1;
      if (tick) begin
        case (rx_st)
          INICIO:   idx <= '0;
          DADOS: begin
            shreg <= {s2, shreg[6:1]};
            idx   <= idx + 3'd1;
          end
          PARIDADE: par <= s2;
          PARADA: begin
            if (((^shreg) ^ par) == 1'b0 && s2) begin
              pronto_rx <= 1'b1;
              db_dado   <= shreg;
            end else begin
              rx_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- command parser ----------------
  ps_t         ps, ps_nx;
  logic        alvo_u, alvo_nx;
  logic [11:0] stg, stg_nx;
  logic        commit_l, commit_u, perr;
  logic        perr_q, lim_q;
  logic        is_dig;

  assign is_dig = (db_dado >= 7'h30) && (db_dado <= 7'h39);

  always_comb begin
    ps_nx    = ps;
    alvo_nx  = alvo_u;
    stg_nx   = stg;
    commit_l = 1'b0;
    commit_u = 1'b0;
    perr     = 1'b0;
    if (rx_err) begin
      ps_nx  = ESPERA_CMD;
      stg_nx = '0;
    end else if (pronto_rx) begin
      case (ps)
        ESPERA_CMD: begin
          if (db_dado == CH_L) begin
            alvo_nx = 1'b0;
            ps_nx   = DIG_C;
          end else if (db_dado == CH_U) begin
            alvo_nx = 1'b1;
            ps_nx   = DIG_C;
          end
        end
        DIG_C, DIG_D, DIG_U: begin
          if (is_dig) begin
            case (ps)
              DIG_C:   begin stg_nx[11:8] = db_dado[3:0]; ps_nx = DIG_D;       end
              DIG_D:   begin stg_nx[7:4]  = db_dado[3:0]; ps_nx = DIG_U;       end
              default: begin stg_nx[3:0]  = db_dado[3:0]; ps_nx = ESPERA_HASH; end
            endcase
          end else begin
            perr  = 1'b1;
            ps_nx = ESPERA_CMD;
          end
        end
        ESPERA_HASH: begin
          ps_nx = ESPERA_CMD;
          // BCD digit order preserves magnitude, so plain unsigned compare is exact
          if (db_dado != CH_HASH)          perr     = 1'b1;
          else if (alvo_u && lowerL <= stg) commit_u = 1'b1;
          else if (!alvo_u && stg <= upperL) commit_l = 1'b1;
          else                               perr     = 1'b1;
        end
        default: ps_nx = ESPERA_CMD;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ps     <= ESPERA_CMD;
      alvo_u <= 1'b0;
      stg    <= '0;
      upperL <= UPPER_DEF;
      lowerL <= LOWER_DEF;
      lim_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ps     <= ps_nx;
      alvo_u <= alvo_nx;
      stg    <= stg_nx;
      if (commit_u) upperL <= stg;
      if (commit_l) lowerL <= stg;
      lim_q  <= commit_u | commit_l;
      perr_q <= perr;
    end
  end

  assign limites_atualizados = lim_q;
  assign erro                = rx_err | perr_q;
  assign db_estado           = ps;

endmodule
